// File: rtl/inv_mix_col_seq_if.sv
// Handshake bundle for the sequential InvMixColumns engine.
// master: upstream/downstream environment; slave: the engine itself.
interface inv_mix_col_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    modport master (
        output in_valid,
        output state_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  state_out,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  state_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output state_out,
        output busy
    );
endinterface

// File: rtl/inv_mix_col_seq.sv
// Sequential AES InvMixColumns: one shared column datapath applied to
// columns 0..3 on consecutive cycles, result held until taken downstream.
module inv_mix_col_seq (
    input  logic               clk,
    input  logic               rst,
    inv_mix_col_seq_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] work_q, work_d;
    logic [31:0]  col_in, col_out;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] a);
        logic [7:0] x [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            x[i]  = a[31 - 8*i -: 8];
            x2[i] = xtime(x[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ x[i];
            mb[i] = x8[i] ^ x2[i] ^ x[i];
            md[i] = x8[i] ^ x4[i] ^ x[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Select the column currently being transformed (col0 is the MSB word).
    always_comb begin
        col_in = work_q[127:96];
        unique case (col_q)
            2'd0: col_in = work_q[127:96];
            2'd1: col_in = work_q[95:64];
            2'd2: col_in = work_q[63:32];
            2'd3: col_in = work_q[31:0];
        endcase
        col_out = inv_col(col_in);
    end

    // Next-state logic: accept, walk the four columns in place, hold for release.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        work_d  = work_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    work_d  = bus.state_in;
                    col_d   = 2'd0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                unique case (col_q)
                    2'd0: work_d[127:96] = col_out;
                    2'd1: work_d[95:64]  = col_out;
                    2'd2: work_d[63:32]  = col_out;
                    2'd3: work_d[31:0]   = col_out;
                endcase
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset; reset aborts any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            col_q   <= 2'd0;
            work_q  <= 128'h0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            work_q  <= work_d;
        end
    end

    // Handshake outputs decode registered state only.
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q == StCalc) || (state_q == StDone);
    assign bus.state_out = work_q;

endmodule

// File: tb/tb_inv_mix_col_seq.sv
// Self-checking bench for inv_mix_col_seq: scoreboard of expected results,
// fixed AES vectors, reset abort, back-pressure, back-to-back and round trip.
module tb_inv_mix_col_seq;

    logic clk;
    logic rst;
    inv_mix_col_seq_if bus ();

    inv_mix_col_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;
    int           cyc = 0;
    logic [127:0] pend_exp = '0;
    logic [127:0] exp_q [$];
    int           acc_q [$];
    bit           ov_prev = 1'b0;
    bit           xfer_prev = 1'b0;

    localparam logic [127:0] FipsIn  = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] FipsOut = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] ColIn   = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
    localparam logic [127:0] ColOut  = 128'hdb135345f20a225c01010101c6c6c6c6;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Forward MixColumns reference, used to build round-trip stimulus.
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] mix_fwd(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            r[103 - 32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log acceptances, check latency, pop scoreboard on each transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (xfer_prev) begin
                check("post_xfer_out_valid", {127'b0, bus.out_valid}, 128'd0);
                check("post_xfer_in_ready", {127'b0, bus.in_ready}, 128'd1);
            end
            xfer_prev = 1'b0;
            if (bus.out_valid && !ov_prev && acc_q.size() > 0) begin
                check("latency", 128'(cyc - acc_q[$]), 128'd4);
            end
            ov_prev = bus.out_valid;
            if (bus.in_valid && bus.in_ready) begin
                acc_q.push_back(cyc + 1);
                exp_q.push_back(pend_exp);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 128'd1, 128'd0);
                end else begin
                    check("data", bus.state_out, exp_q.pop_front());
                end
                xfer_prev = 1'b1;
            end
        end else begin
            ov_prev   = 1'b0;
            xfer_prev = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one block; returns just after its acceptance edge with in_valid still high.
    task automatic offer(input logic [127:0] s, input logic [127:0] e);
        int n;
        bus.in_valid = 1'b1;
        bus.state_in = s;
        pend_exp     = e;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 128'd1, 128'd0);
        step();
    endtask

    task automatic send(input logic [127:0] s, input logic [127:0] e);
        offer(s, e);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("drain_timeout", 128'd1, 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] orig;
        logic [127:0] frozen;
        int n;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.state_in = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset_in_ready", {127'b0, bus.in_ready}, 128'd1);
        check("reset_out_valid", {127'b0, bus.out_valid}, 128'd0);
        check("reset_busy", {127'b0, bus.busy}, 128'd0);
        check("reset_state_out", bus.state_out, 128'h0);

        // FIPS vector, streaming output.
        send(FipsIn, FipsOut);
        wait_drain();

        // Column ordering / independence.
        send(ColIn, ColOut);
        wait_drain();

        // Reset mid-CALC aborts the block.
        send(FipsIn, FipsOut);
        step();
        check("mid_calc_busy", {127'b0, bus.busy}, 128'd1);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
        check("abort_out_valid", {127'b0, bus.out_valid}, 128'd0);
        check("abort_in_ready", {127'b0, bus.in_ready}, 128'd1);
        check("abort_state_out", bus.state_out, 128'h0);
        check("abort_busy", {127'b0, bus.busy}, 128'd0);
        for (int i = 0; i < 10; i++) begin
            check("abort_no_valid", {127'b0, bus.out_valid}, 128'd0);
            step();
        end

        // Back-pressure: hold DONE, ignore a competing input.
        bus.out_ready = 1'b0;
        send(FipsIn, FipsOut);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        check("bp_out_valid", {127'b0, bus.out_valid}, 128'd1);
        frozen = bus.state_out;
        check("bp_value", frozen, FipsOut);
        for (int i = 0; i < 7; i++) begin
            if (i == 2) begin
                bus.in_valid = 1'b1;
                bus.state_in = ColIn;
                pend_exp     = ColOut;
            end
            step();
            check("bp_stable", bus.state_out, FipsOut);
            check("bp_in_ready", {127'b0, bus.in_ready}, 128'd0);
            check("bp_out_valid_hold", {127'b0, bus.out_valid}, 128'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();
        check("bp_single_xfer", 128'(exp_q.size()), 128'd0);

        // Back-to-back with in_valid held high.
        offer(FipsIn, FipsOut);
        bus.state_in = ColIn;
        pend_exp     = ColOut;
        offer(ColIn, ColOut);
        bus.in_valid = 1'b0;
        wait_drain();
        check("b2b_spacing", 128'(acc_q[$] - acc_q[$-1]), 128'd6);

        // Round trip through forward MixColumns model.
        for (int i = 0; i < 50; i++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            send(mix_fwd(orig), orig);
        end
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
